// File: rtl/p_int_div_pow2_pkg.sv
// Shared perceptron datapath package: data configuration type, rounding modes and stat widths.
// DEF_DCONF is the default lane configuration used when a block is not overridden.
`ifndef DEF_DCONF
`define DEF_DCONF '{sign: 1'b1, prec: 8'd16}
`endif

package p_int_div_pow2_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] prec;
  } dconf_t;

  typedef enum logic [1:0] {
    RND_TRUNC = 2'd0,
    RND_HALF  = 2'd1,
    RND_NZ    = 2'd2
  } rnd_mode_t;

  localparam int SAT_CNT_W = 16;

endpackage

// File: rtl/p_int_rshift_rnd.sv
// Per-lane magnitude, right shift, round increment and remainder (combinational).
// The shift amount arrives already clamped to SHIFT_MAX; SHIFT_MAX must not exceed I_PREC.
module p_int_rshift_rnd
  import p_int_div_pow2_pkg::*;
#(
  parameter int I_PREC    = 16,
  parameter bit I_SIGN    = 1'b1,
  parameter int SHIFT_MAX = 8,
  parameter int SHIFT_W   = $clog2(SHIFT_MAX + 1)
) (
  input  logic [I_PREC-1:0]    din,
  input  logic [SHIFT_W-1:0]   shift,
  input  logic [1:0]           rnd,
  output logic                 sgn,
  output logic [I_PREC:0]      quo,
  output logic                 rinc,
  output logic [SHIFT_MAX-1:0] rem
);

  logic [I_PREC:0] mag;
  logic            half_bit;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sgn      = I_SIGN & din[I_PREC-1];
    // One extra bit keeps |most negative| exact.
    mag      = sgn ? -{din[I_PREC-1], din} : {1'b0, din};
    quo      = mag >> shift;
    rem      = '0;
    half_bit = 1'b0;
    rinc     = 1'b0;
    for (int i = 0; i < SHIFT_MAX; i++) begin
      if (i < int'(shift))      rem[i]   = mag[i];
      if (i + 1 == int'(shift)) half_bit = mag[i];
    end
    // With shift 0 both rem and half_bit are 0, so no increment is possible.
    case (rnd)
      RND_HALF: rinc = half_bit;
      RND_NZ:   rinc = |rem;
      default:  rinc = 1'b0;
    endcase
  end

endmodule

// File: rtl/p_int_div_pow2_pipe.sv
// Two-stage, multi-lane signed/unsigned divide by 2^k with rounding, saturation and valid/ready.
// Optional saturation statistics counter under `P_DIV_POW2_STAT_EN.
module p_int_div_pow2_pipe
  import p_int_div_pow2_pkg::*;
#(
  parameter int     LANES     = 4,
  parameter int     SHIFT_MAX = 8,
  parameter int     SHIFT_W   = $clog2(SHIFT_MAX + 1),
  parameter dconf_t I_CONF    = `DEF_DCONF,
  parameter dconf_t O_CONF    = `DEF_DCONF,
  parameter int     I_PREC    = int'(I_CONF.prec),
  parameter int     O_PREC    = int'(O_CONF.prec)
) (
  input  logic                       clk,
  input  logic                       reset_,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*I_PREC-1:0]    in_data,
  input  logic [SHIFT_W-1:0]         in_shift,
  input  logic [1:0]                 in_round,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*O_PREC-1:0]    out_data,
  output logic [LANES*SHIFT_MAX-1:0] out_rem,
  output logic [LANES-1:0]           out_ovf
`ifdef P_DIV_POW2_STAT_EN
  ,
  input  logic                       stat_clr,
  output logic [SAT_CNT_W-1:0]       sat_cnt
`endif
);

  localparam int V_W = I_PREC + 2;
  localparam logic signed [V_W-1:0] O_MAX = O_CONF.sign ?
      V_W'((64'sd1 <<< (O_PREC - 1)) - 64'sd1) : V_W'((64'sd1 <<< O_PREC) - 64'sd1);
  localparam logic signed [V_W-1:0] O_MIN = O_CONF.sign ?
      V_W'(-(64'sd1 <<< (O_PREC - 1))) : V_W'(0);

  logic [SHIFT_W-1:0]                 k;
  logic [LANES-1:0]                   lane_sgn, lane_rinc;
  logic [LANES-1:0][I_PREC:0]         lane_quo;
  logic [LANES-1:0][SHIFT_MAX-1:0]    lane_rem;

  logic                               s1_load, s2_load;
  logic                               s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [LANES-1:0]                   s1_sgn_q, s1_sgn_d, s1_rinc_q, s1_rinc_d;
  logic [LANES-1:0][I_PREC:0]         s1_quo_q, s1_quo_d;
  logic [LANES-1:0][SHIFT_MAX-1:0]    s1_rem_q, s1_rem_d, s2_rem_q, s2_rem_d;
  logic [LANES-1:0][O_PREC-1:0]       s2_data_q, s2_data_d;
  logic [LANES-1:0]                   s2_ovf_q, s2_ovf_d;
  logic signed [V_W-1:0]              v_sum, v_val;

  assign k = (in_shift > SHIFT_W'(SHIFT_MAX)) ? SHIFT_W'(SHIFT_MAX) : in_shift;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    p_int_rshift_rnd #(
      .I_PREC   (I_PREC),
      .I_SIGN   (I_CONF.sign),
      .SHIFT_MAX(SHIFT_MAX),
      .SHIFT_W  (SHIFT_W)
    ) u_rshift (
      .din  (in_data[g*I_PREC +: I_PREC]),
      .shift(k),
      .rnd  (in_round),
      .sgn  (lane_sgn[g]),
      .quo  (lane_quo[g]),
      .rinc (lane_rinc[g]),
      .rem  (lane_rem[g])
    );
  end

  always_comb begin
    s2_load    = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready   = !s1_valid_q || !s2_valid_q || out_ready;
    s1_load    = in_valid && in_ready;
    s1_valid_d = s1_load || (s1_valid_q && !s2_load);
    s2_valid_d = s2_load || (s2_valid_q && !out_ready);

    s1_sgn_d  = s1_sgn_q;
    s1_quo_d  = s1_quo_q;
    s1_rinc_d = s1_rinc_q;
    s1_rem_d  = s1_rem_q;
    s2_data_d = s2_data_q;
    s2_rem_d  = s2_rem_q;
    s2_ovf_d  = s2_ovf_q;
    v_sum     = '0;
    v_val     = '0;

    if (s1_load) begin
      s1_sgn_d  = lane_sgn;
      s1_quo_d  = lane_quo;
      s1_rinc_d = lane_rinc;
      s1_rem_d  = lane_rem;
    end

    if (s2_load) begin
      s2_rem_d = s1_rem_q;
      for (int l = 0; l < LANES; l++) begin
        v_sum = V_W'(s1_quo_q[l]) + V_W'(s1_rinc_q[l]);
        v_val = s1_sgn_q[l] ? -v_sum : v_sum;
        if (v_val > O_MAX) begin
          s2_data_d[l] = O_MAX[O_PREC-1:0];
          s2_ovf_d[l]  = 1'b1;
        end else if (v_val < O_MIN) begin
          s2_data_d[l] = O_MIN[O_PREC-1:0];
          s2_ovf_d[l]  = 1'b1;
        end else begin
          s2_data_d[l] = v_val[O_PREC-1:0];
          s2_ovf_d[l]  = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      // NOTE: data registers are reset too, because the outputs must read 0 while in reset.
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_sgn_q   <= '0;
      s1_quo_q   <= '0;
      s1_rinc_q  <= '0;
      s1_rem_q   <= '0;
      s2_data_q  <= '0;
      s2_rem_q   <= '0;
      s2_ovf_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_sgn_q   <= s1_sgn_d;
      s1_quo_q   <= s1_quo_d;
      s1_rinc_q  <= s1_rinc_d;
      s1_rem_q   <= s1_rem_d;
      s2_data_q  <= s2_data_d;
      s2_rem_q   <= s2_rem_d;
      s2_ovf_q   <= s2_ovf_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_rem   = s2_rem_q;
  assign out_ovf   = s2_ovf_q;

`ifdef P_DIV_POW2_STAT_EN
  logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (stat_clr) begin
      sat_cnt_d = '0;
    end else if (s2_valid_q && out_ready && (|s2_ovf_q) && (sat_cnt_q != '1)) begin
      sat_cnt_d = sat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) sat_cnt_q <= '0;
    else         sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_p_int_div_pow2_pipe.sv
// Scoreboard bench for p_int_div_pow2_pipe: 4 lanes, 16-bit signed in, 8-bit signed out.
// Stat counter scenarios are compiled in when `P_DIV_POW2_STAT_EN is defined.
module tb_p_int_div_pow2_pipe;
  import p_int_div_pow2_pkg::*;

  localparam int LANES     = 4;
  localparam int SHIFT_MAX = 8;
  localparam int SHIFT_W   = 4;
  localparam int IP        = 16;
  localparam int OP        = 8;
  localparam dconf_t TB_I_CONF = '{sign: 1'b1, prec: 8'd16};
  localparam dconf_t TB_O_CONF = '{sign: 1'b1, prec: 8'd8};

  logic                       clk;
  logic                       reset_;
  logic                       in_valid, in_ready;
  logic [LANES*IP-1:0]        in_data;
  logic [SHIFT_W-1:0]         in_shift;
  logic [1:0]                 in_round;
  logic                       out_valid, out_ready;
  logic [LANES*OP-1:0]        out_data;
  logic [LANES*SHIFT_MAX-1:0] out_rem;
  logic [LANES-1:0]           out_ovf;
`ifdef P_DIV_POW2_STAT_EN
  logic                       stat_clr;
  logic [SAT_CNT_W-1:0]       sat_cnt;
`endif

  typedef struct {
    logic [LANES*OP-1:0]        data;
    logic [LANES*SHIFT_MAX-1:0] rem;
    logic [LANES-1:0]           ovf;
    int                         t_in;
    bit                         chk_lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   stall_at   = -1;
  int   stall_left = 0;
  int   rdy_drops  = 0;
  bit   rand_rdy   = 1'b0;
  bit   b2b_mode   = 1'b0;
  bit   saw_rdy_low = 1'b0;

  p_int_div_pow2_pipe #(
    .LANES    (LANES),
    .SHIFT_MAX(SHIFT_MAX),
    .SHIFT_W  (SHIFT_W),
    .I_CONF   (TB_I_CONF),
    .O_CONF   (TB_O_CONF)
  ) dut (
    .clk      (clk),
    .reset_   (reset_),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shift (in_shift),
    .in_round (in_round),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_rem  (out_rem),
    .out_ovf  (out_ovf)
`ifdef P_DIV_POW2_STAT_EN
    ,
    .stat_clr (stat_clr),
    .sat_cnt  (sat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  // Arithmetic reference: divide the magnitude, round, reapply sign, clamp to 8-bit signed.
  function automatic void model_lane(input int x, input int k, input int mode,
                                     output int v, output int rm, output bit ovf);
    int kk, p, mag, q, r;
    kk  = (k > SHIFT_MAX) ? SHIFT_MAX : k;
    p   = 1 << kk;
    mag = (x < 0) ? -x : x;
    q   = mag / p;
    rm  = mag % p;
    r   = 0;
    if (mode == 1 && kk > 0 && rm >= p / 2) r = 1;
    if (mode == 2 && rm != 0) r = 1;
    v   = (x < 0) ? -(q + r) : (q + r);
    ovf = 1'b0;
    if (v > 127) begin
      v = 127; ovf = 1'b1;
    end else if (v < -128) begin
      v = -128; ovf = 1'b1;
    end
  endfunction

  task automatic send(input int a, input int b, input int c, input int d,
                      input int k, input int mode, input bit lat);
    int   x[4];
    exp_t e;
    int   v, rm, waited;
    bit   ov;
    x = '{a, b, c, d};
    for (int i = 0; i < LANES; i++) begin
      in_data[i*IP +: IP] = x[i][IP-1:0];
      model_lane(x[i], k, mode, v, rm, ov);
      e.data[i*OP +: OP]               = v[OP-1:0];
      e.rem[i*SHIFT_MAX +: SHIFT_MAX]  = rm[SHIFT_MAX-1:0];
      e.ovf[i]                         = ov;
    end
    in_shift = SHIFT_W'(k);
    in_round = 2'(mode);
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      saw_rdy_low = 1'b1;
      if (b2b_mode) rdy_drops++;
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    e.t_in    = cyc + 1;
    e.chk_lat = lat;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("lost_txn", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  // Output monitor: every valid cycle is compared, so stalled outputs must stay stable.
  always @(negedge clk) begin
    if (reset_ && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'd1, 64'd0);
      end else begin
        check("out_data", 64'(out_data), 64'(exp_q[0].data));
        check("out_rem",  64'(out_rem),  64'(exp_q[0].rem));
        check("out_ovf",  64'(out_ovf),  64'(exp_q[0].ovf));
        if (out_ready) begin
          if (exp_q[0].chk_lat) check("latency", 64'(cyc + 1 - exp_q[0].t_in), 64'd2);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_at == cyc) stall_left = 3;
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_shift = '0;
    in_round = '0;
`ifdef P_DIV_POW2_STAT_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_rem",   64'(out_rem),   64'd0);
    check("rst_out_ovf",   64'(out_ovf),   64'd0);
    @(negedge clk);
    reset_ = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    for (int m = 0; m < 4; m++) send(-7, 6, -6, 5, 2, m, 1'b0);
    send(1000, -1000, -32768, 508, 2, 0, 1'b0);
    send(5, -5, 5, -5, 0, 0, 1'b0);
    send(256, 256, -256, 0, 15, 1, 1'b0);
    send(128, -128, 127, -129, 8, 1, 1'b0);
    send(32767, -32768, 0, -1, 0, 2, 1'b0);
    drain();

    b2b_mode = 1'b1;
    for (int i = 0; i < 8; i++)
      send(rnd16(), rnd16(), rnd16(), rnd16(), i % 9, i % 3, 1'b1);
    b2b_mode = 1'b0;
    drain();
    check("b2b_rdy_drops", 64'(rdy_drops), 64'd0);

    saw_rdy_low = 1'b0;
    stall_at    = cyc + 3;
    for (int i = 0; i < 8; i++)
      send(rnd16(), rnd16(), rnd16(), rnd16(), 3, i % 4, 1'b0);
    drain();
    check("stall_rdy_fell", 64'(saw_rdy_low), 64'd1);

    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++)
      send(rnd16(), rnd16(), rnd16(), rnd16(), int'($urandom_range(15)),
           int'($urandom_range(3)), 1'b0);
    rand_rdy = 1'b0;
    drain();

    send(100, -100, 7, -7, 1, 0, 1'b0);
    send(200, -200, 9, -9, 1, 1, 1'b0);
    reset_ = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data",  64'(out_data),  64'd0);
    check("midrst_out_rem",   64'(out_rem),   64'd0);
    check("midrst_out_ovf",   64'(out_ovf),   64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_ = 1'b1;
    @(posedge clk);
    #1;
    send(-9, 9, 33, -33, 2, 2, 1'b1);
    drain();

`ifdef P_DIV_POW2_STAT_EN
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    send(1000, 0, 0, 0, 2, 0, 1'b0);
    send(5, 6, 7, 8, 0, 0, 1'b0);
    send(0, -1000, 0, 0, 2, 0, 1'b0);
    send(0, 0, 600, -32768, 1, 1, 1'b0);
    drain();
    check("sat_cnt_3", 64'(sat_cnt), 64'd3);
    stat_clr = 1'b1;
    send(2000, 0, 0, 0, 1, 0, 1'b0);
    drain();
    check("sat_cnt_clr_wins", 64'(sat_cnt), 64'd0);
    stat_clr = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/p_int_div_pow2_pipe.md
Name: p_int_div_pow2_pipe

Overview:
- Multi-lane, pipelined, signed/unsigned integer divide by 2^k with runtime shift amount and runtime rounding mode.
- Narrows each result to O_PREC with saturation and a per-lane overflow flag.
- Sits between MAC accumulators and activation/weight-update logic in the perceptron datapath.
- Uses a valid/ready stream interface, so it can be stalled by downstream consumers.

Parameters:
- LANES, 4, number of parallel lanes; all lanes share one shift amount and one round mode per transaction.
- SHIFT_MAX, 8, largest legal shift amount.
- SHIFT_W, $clog2(SHIFT_MAX+1), width of the shift port.
- I_CONF, `DEF_DCONF, input data configuration (sign, prec).
- O_CONF, `DEF_DCONF, output data configuration (sign, prec).
- I_PREC, I_CONF.prec, input width per lane.
- O_PREC, O_CONF.prec, output width per lane; O_PREC <= I_PREC.

Ports:
- clk  in  1  clock.
- reset_  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept an input transaction.
- in_data  in  LANES*I_PREC  packed lanes; lane i occupies [i*I_PREC +: I_PREC].
- in_shift  in  SHIFT_W  shift amount k.
- in_round  in  2  round mode: 0 = truncate toward zero, 1 = round half away from zero, 2 = round away from zero when any discarded bit is nonzero, 3 = reserved (treated as 0).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  LANES*O_PREC  packed results.
- out_rem  out  LANES*SHIFT_MAX  lower k bits of the input magnitude; bits at and above k are 0.
- out_ovf  out  LANES  per-lane saturation occurred.

Behaviour:
- Transfer rule: a transfer occurs on a rising clk edge where valid && ready. Latency is exactly 2 cycles from input transfer to out_valid when there is no stall.
- Stage 1 (S1) registers, per lane:
  - sign s = I_CONF.sign ? msb : 0.
  - magnitude m = |in|, computed in I_PREC+1 bits so that the most negative input is exact.
  - q = m >> k.
  - round increment r: mode 0 gives r=0; mode 1 gives r = bit[k-1] of m; mode 2 gives r = |m[k-1:0]. When k=0, r=0.
  - rem.
- Stage 2 (S2) registers: v = s ? -(q+r) : (q+r), saturated to the O_CONF range, with ovf=1 when clamped.
  - Unsigned output with a negative v clamps to 0 and sets ovf.
- Shift clamping: in_shift > SHIFT_MAX is clamped to SHIFT_MAX; no error flag.
- k=0: out = in, subject only to saturation; rem = 0.
- Handshake, per stage:
  - A stage loads when its upstream is valid and the stage is empty or draining.
  - in_ready = !s1_valid || !s2_valid || out_ready. This gives full throughput of 1 transaction per cycle with no bubbles.
  - out_data, out_rem and out_ovf are held stable while out_valid && !out_ready.
  - in_data is not required to be stable after the transfer.
- Simultaneous events: an S2 drain and an S1 advance in the same cycle are both legal; S1 may reload in that same cycle.
- Reset: all valids = 0; out_data, out_rem and out_ovf = 0; in_ready = 1 after reset is released. An asserted reset mid-operation discards in-flight transactions with no partial output.
- Reserved round mode 3 behaves exactly as mode 0.

Optional Feature:
- Macro: P_DIV_POW2_STAT_EN.
- Enabled:
  - Adds output port sat_cnt, 16 bits: a count of output transfers with any out_ovf bit set. It saturates at 0xFFFF and does not wrap.
  - Adds input stat_clr, 1 bit: synchronous clear. When stat_clr and a counted transfer coincide, the clear wins and the counter becomes 0.
  - Reset value 0.
- Disabled: neither port exists and no counter logic is built.

Decomposition:
- The shared perceptron package holds:
  - a typedef enum rnd_mode_t {RND_TRUNC=0, RND_HALF=1, RND_NZ=2};
  - a localparam for the sat_cnt width (16).
  - dconf_t is reused unchanged.
- One sub-module: p_int_rshift_rnd, a combinational per-lane magnitude/shift/round-increment/remainder unit, instantiated LANES times ahead of the S1 registers.
- Sign application and saturation stay in the top level.

Test Plan:
- I 16-bit signed, O 8-bit signed, k=2, lane values {-7, 6, -6, 5}:
  - mode 0 -> {-1, 1, -1, 1}.
  - mode 1 -> {-2, 2, -2, 1}.
  - mode 2 -> {-2, 2, -2, 2}.
  - rem -> {3, 2, 2, 1}; ovf = 0.
- Saturation, k=2, lanes {1000, -1000, -32768, 508}, mode 0 -> out {127, -128, -128, 127}, ovf {1, 1, 1, 0}.
- Boundary shifts:
  - k=0 with {5, -5} -> {5, -5}, rem 0.
  - in_shift=15 (clamped to 8) with 256 -> 1.
  - k=8, mode 1, with 128 -> 1, rem 0x80.
- Back-to-back transfers: 8 consecutive transactions with out_ready held at 1 -> first out_valid 2 cycles after the first transfer, then 8 consecutive results in order, in_ready never drops.
- Stall: drop out_ready for 3 cycles while streaming.
  - in_ready falls once S1 and S2 are full.
  - out_data is held stable through the stall.
  - No transaction is lost or duplicated.
- Reset with two transactions in flight -> out_valid = 0 and all outputs 0 immediately (asynchronously); the first output after reset release is the first new input.
- With P_DIV_POW2_STAT_EN:
  - 3 saturating transfers -> sat_cnt = 3.
  - stat_clr coinciding with a saturating transfer -> sat_cnt = 0.
